pwm_ramp_sequencer: RTL and testbench
=====================================

// Module: pwm_ramp_sequencer
// PURPOSE
//   Sequences the duty word of the ramp PWM generator through a trapezoid profile:
//   ramp up to a target, hold, ramp down to zero. Drives the generator's compare value.
//   Updates duty only on the generator's period boundary, so no PWM period sees a mid-period change.
//   Sits between the control logic (start/stop/abort) and the PWM counter/comparator.
// PARAMETERS
//   CLK_HZ     50_000_000  system clock frequency, Hz
//   RAMP_FREQ  1_000       full-scale (0 -> 2^PWM_BITS-1, step 1) ramps per second
//   PWM_BITS   10          duty/target/step width
//   HOLD_BITS  16          width of hold-duration field, in PWM periods
// PORTS
//   clk           in   1          system clock, rising edge
//   rst           in   1          asynchronous reset, active-high
//   start         in   1          begin profile; sampled only in IDLE
//   stop          in   1          graceful stop: UP/HOLD -> DOWN
//   abort         in   1          immediate stop: duty forced 0, go IDLE
//   target        in   PWM_BITS   plateau duty, latched on accepted start
//   step          in   PWM_BITS   duty increment/decrement per step, latched on start
//   hold_periods  in   HOLD_BITS  plateau length in period_end pulses, latched on start
//   period_end    in   1          1-cycle pulse from PWM counter wrap
//   duty          out  PWM_BITS   compare value to PWM generator
//   state         out  2          0=IDLE 1=UP 2=HOLD 3=DOWN
//   busy          out  1          1 when state != IDLE
//   done          out  1          1-cycle pulse on DOWN -> IDLE completion
// BEHAVIOUR
//   Reset (async): duty=0, state=IDLE, busy=0, done=0, prescaler=0, pending=0, hold counter=0.
//   All outputs registered. Reset mid-operation aborts the profile at once, with no done pulse.
//   Step prescaler: STEP_DIV = max(1, CLK_HZ/(RAMP_FREQ<<PWM_BITS)), runs free while busy, cleared in IDLE.
//     Its tick sets the pending flag. Pending is cleared when a step is applied.
//     Several ticks per period merge: at most one step is applied per period_end.
//   A step is applied on a cycle with period_end=1 and pending=1 (or a tick in the same cycle).
//   Start: in IDLE with start=1 and abort=0, latch target, step (0 is treated as 1) and hold_periods.
//     Next edge: state=UP, busy=1. Start is ignored while busy.
//   UP: if duty==target, go HOLD on the next edge, without waiting for a step (covers target=0).
//     Otherwise an applied step sets duty=min(duty+step, target). Sum is computed PWM_BITS+1 wide, so no wrap.
//   HOLD entry: load the hold counter with hold_periods.
//     Each period_end decrements it. At 0 (including hold_periods=0), go DOWN on the next edge.
//   DOWN: an applied step sets duty = (duty<step) ? 0 : duty-step, which saturates and never underflows.
//     When duty==0, go IDLE on the next edge with done=1 for exactly that cycle.
//   stop (UP or HOLD): go DOWN on the next edge. duty holds its current value. Ignored in IDLE/DOWN.
//   abort (any state): next edge duty=0, state=IDLE, pending cleared, done=0.
//   Priority: rst > abort > stop > start > normal step.
// TESTING  (CLK_HZ=64, RAMP_FREQ=1, PWM_BITS=4 -> STEP_DIV=4; bench pulses period_end every 16 clk)
//   start, target=10, step=3, hold=2 -> duty 3,6,9,10 on successive period_end; HOLD 2 periods;
//     then 7,4,1,0; IDLE; exactly one done pulse.
//   stop asserted in UP at duty=6 -> DOWN next edge; duty 3,0; done pulses.
//   abort during DOWN at duty=7 -> duty=0, state=IDLE next edge, no done.
//   step=0, target=2 -> treated as step 1: duty 1,2.
//   start while busy -> ignored; latched target unchanged.
//   hold=0, target=15, step=15 -> duty 15, then DOWN immediately, then 0.
//   rst pulse mid-UP (between clk edges) -> duty=0, busy=0 without waiting for a clk edge.
//   start+abort same cycle in IDLE -> stays IDLE.
//   Run with period_end every 2 clk (steps merge on the slower tick) and check that duty never changes without period_end.

Source files
------------

// File: rtl/pwm_ramp_sequencer.sv
// Trapezoid duty sequencer for the ramp PWM generator: ramp up, hold, ramp down.
// Duty only moves on the generator's period boundary, so every PWM period sees one stable compare value.
module pwm_ramp_sequencer #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int RAMP_FREQ = 1_000,
    parameter int PWM_BITS  = 10,
    parameter int HOLD_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 abort,
    input  logic [PWM_BITS-1:0]  target,
    input  logic [PWM_BITS-1:0]  step,
    input  logic [HOLD_BITS-1:0] hold_periods,
    input  logic                 period_end,
    output logic [PWM_BITS-1:0]  duty,
    output logic [1:0]           state,
    output logic                 busy,
    output logic                 done
);

    localparam longint RAW_DIV  = longint'(CLK_HZ) / (longint'(RAMP_FREQ) << PWM_BITS);
    localparam int     STEP_DIV = (RAW_DIV < 1) ? 1 : int'(RAW_DIV);
    localparam int     PW       = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        HOLD = 2'd2,
        DOWN = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [PWM_BITS-1:0]  duty_q, duty_d;
    logic [PWM_BITS-1:0]  target_q, target_d;
    logic [PWM_BITS-1:0]  step_q, step_d;
    logic [HOLD_BITS-1:0] hold_q, hold_d;
    logic [HOLD_BITS-1:0] holdCnt_q, holdCnt_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic                 pending_q, pending_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 tick;
    logic                 stepNow;
    logic                 consume;
    logic [PWM_BITS:0]    upSum;
    logic [PWM_BITS-1:0]  upDuty;
    logic [PWM_BITS-1:0]  downDuty;

    // The prescaler tick only arms a step; the step itself waits for the period boundary.
    assign tick     = (state_q != IDLE) && (presc_q == PRESC_LAST);
    assign stepNow  = period_end && (pending_q || tick);
    assign upSum    = {1'b0, duty_q} + {1'b0, step_q};
    assign upDuty   = (upSum > {1'b0, target_q}) ? target_q : upSum[PWM_BITS-1:0];
    assign downDuty = (duty_q < step_q) ? '0 : (duty_q - step_q);

    always_comb begin
        state_d   = state_q;
        duty_d    = duty_q;
        target_d  = target_q;
        step_d    = step_q;
        hold_d    = hold_q;
        holdCnt_d = holdCnt_q;
        done_d    = 1'b0;
        consume   = 1'b0;

        if (abort) begin
            state_d = IDLE;
            duty_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        target_d = target;
                        step_d   = (step == '0) ? {{(PWM_BITS-1){1'b0}}, 1'b1} : step;
                        hold_d   = hold_periods;
                        state_d  = UP;
                    end
                end
                UP: begin
                    if (stop) begin
                        state_d = DOWN;
                    end else if (duty_q == target_q) begin
                        state_d   = HOLD;
                        holdCnt_d = hold_q;
                    end else if (stepNow) begin
                        duty_d  = upDuty;
                        consume = 1'b1;
                    end
                end
                HOLD: begin
                    if (stop || (holdCnt_q == '0)) begin
                        state_d = DOWN;
                    end else if (period_end) begin
                        holdCnt_d = holdCnt_q - 1'b1;
                    end
                end
                DOWN: begin
                    if (duty_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (stepNow) begin
                        duty_d  = downDuty;
                        consume = 1'b1;
                    end
                end
            endcase
        end

        // Prescaler and pending flag only live while a profile is running.
        presc_d   = ((state_q == IDLE) || tick) ? '0 : (presc_q + 1'b1);
        pending_d = (abort || (state_q == IDLE) || consume) ? 1'b0 : (pending_q | tick);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            duty_q    <= '0;
            target_q  <= '0;
            step_q    <= '0;
            hold_q    <= '0;
            holdCnt_q <= '0;
            presc_q   <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            duty_q    <= duty_d;
            target_q  <= target_d;
            step_q    <= step_d;
            hold_q    <= hold_d;
            holdCnt_q <= holdCnt_d;
            presc_q   <= presc_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign duty  = duty_q;
    assign state = state_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Bench for pwm_ramp_sequencer: directed profiles checked against a cycle-level behavioural model
// and against hand-computed duty sequences.
module tb_pwm_ramp_sequencer;

    localparam int CLK_HZ    = 64;
    localparam int RAMP_FREQ = 1;
    localparam int PWM_BITS  = 4;
    localparam int HOLD_BITS = 16;
    localparam int STEP_DIV  = CLK_HZ / (RAMP_FREQ * (1 << PWM_BITS));

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic                 stop = 1'b0;
    logic                 abort = 1'b0;
    logic                 period_end = 1'b0;
    logic [PWM_BITS-1:0]  target = '0;
    logic [PWM_BITS-1:0]  step = '0;
    logic [HOLD_BITS-1:0] hold_periods = '0;
    logic [PWM_BITS-1:0]  duty;
    logic [1:0]           state;
    logic                 busy;
    logic                 done;

    int checks = 0;
    int failures = 0;
    int peDiv = 16;
    bit modelOn = 1'b0;

    pwm_ramp_sequencer #(
        .CLK_HZ(CLK_HZ), .RAMP_FREQ(RAMP_FREQ), .PWM_BITS(PWM_BITS), .HOLD_BITS(HOLD_BITS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .abort(abort),
        .target(target), .step(step), .hold_periods(hold_periods), .period_end(period_end),
        .duty(duty), .state(state), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Period boundary source: one-cycle pulse every peDiv clocks, changed on the falling edge.
    initial begin
        int peCnt;
        peCnt = 0;
        forever begin
            @(negedge clk);
            peCnt++;
            if (peCnt >= peDiv) begin
                peCnt = 0;
                period_end = 1'b1;
            end else begin
                period_end = 1'b0;
            end
        end
    end

    // Behavioural model: profile phase, duty, busy-cycle count and "tick since last step" flag.
    int mState, mDuty, mTarget, mStep, mHold, mHoldLeft, mBusyCycles;
    bit mPending, mDone, lastEdgePe;

    always @(posedge clk or posedge rst) begin : model
        int nState, nDuty, nHoldLeft;
        bit tick, stepNow, used;
        if (rst) begin
            mState = 0; mDuty = 0; mTarget = 0; mStep = 0; mHold = 0;
            mHoldLeft = 0; mBusyCycles = 0; mPending = 0; mDone = 0;
            lastEdgePe = 1;
        end else begin
            tick = (mState != 0) && ((mBusyCycles % STEP_DIV) == STEP_DIV - 1);
            stepNow = period_end && (mPending || tick);
            used = 0;
            nState = mState; nDuty = mDuty; nHoldLeft = mHoldLeft;
            mDone = 0;
            lastEdgePe = period_end || abort;
            if (abort) begin
                nState = 0; nDuty = 0;
            end else if (mState == 0) begin
                if (start) begin
                    mTarget = int'(target);
                    mStep = (step == 0) ? 1 : int'(step);
                    mHold = int'(hold_periods);
                    nState = 1;
                end
            end else if (mState == 1) begin
                if (stop) nState = 3;
                else if (mDuty == mTarget) begin nState = 2; nHoldLeft = mHold; end
                else if (stepNow) begin
                    nDuty = (mDuty + mStep > mTarget) ? mTarget : mDuty + mStep;
                    used = 1;
                end
            end else if (mState == 2) begin
                if (stop || mHoldLeft == 0) nState = 3;
                else if (period_end) nHoldLeft = mHoldLeft - 1;
            end else begin
                if (mDuty == 0) begin nState = 0; mDone = 1; end
                else if (stepNow) begin
                    nDuty = (mDuty - mStep < 0) ? 0 : mDuty - mStep;
                    used = 1;
                end
            end
            if (abort || mState == 0 || used) mPending = 0;
            else if (tick) mPending = 1;
            mBusyCycles = (mState == 0) ? 0 : mBusyCycles + 1;
            mState = nState; mDuty = nDuty; mHoldLeft = nHoldLeft;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison against the model, plus the rule that duty only moves on a boundary.
    int prevDuty = 0;
    always @(negedge clk) begin
        if (modelOn) begin
            checkOutput("model.duty", int'(duty), mDuty);
            checkOutput("model.state", int'(state), mState);
            checkOutput("model.busy", int'(busy), (mState != 0) ? 1 : 0);
            checkOutput("model.done", int'(done), int'(mDone));
            checkOutput("dutyOnlyAtPeriodEnd", (int'(duty) == prevDuty || lastEdgePe) ? 1 : 0, 1);
        end
        prevDuty = int'(duty);
    end

    // Record every duty change and count done pulses and HOLD boundaries.
    int changes[$];
    int lastDuty = 0;
    int doneCount = 0;
    int holdPe = 0;
    always @(negedge clk) begin
        if (int'(duty) != lastDuty) begin
            changes.push_back(int'(duty));
            lastDuty = int'(duty);
        end
        if (done) doneCount++;
    end
    always @(posedge clk) begin
        if (state == 2'd2 && period_end) holdPe++;
    end

    task automatic clearRecords();
        changes.delete();
        lastDuty = int'(duty);
        doneCount = 0;
        holdPe = 0;
    endtask

    task automatic applyStimulus(input int t, input int s, input int h);
        @(negedge clk);
        target = PWM_BITS'(t);
        step = PWM_BITS'(s);
        hold_periods = HOLD_BITS'(h);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitFor(input string name, input int wantDuty, input int wantState, input int budget);
        int n;
        n = 0;
        while (!((wantDuty < 0 || int'(duty) == wantDuty) && (wantState < 0 || int'(state) == wantState))
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("[TB] FAIL %s: timeout, duty=%0d state=%0d wanted duty=%0d state=%0d",
                     name, duty, state, wantDuty, wantState);
        end
    endtask

    task automatic checkSeq(input string name, input int exp[$]);
        string got;
        bit ok;
        got = "";
        checks++;
        ok = (changes.size() == exp.size());
        foreach (changes[i]) begin
            got = {got, $sformatf("%0d ", changes[i])};
            if (ok && changes[i] != exp[i]) ok = 0;
        end
        if (!ok) begin
            failures++;
            $display("[TB] FAIL %s: duty sequence got { %s} expected %0d values starting %0d",
                     name, got, exp.size(), exp[0]);
        end
    endtask

    initial begin
        int exp[$];

        #1 rst = 1'b1;
        #12;
        checkOutput("reset.duty", int'(duty), 0);
        checkOutput("reset.state", int'(state), 0);
        checkOutput("reset.busy", int'(busy), 0);
        checkOutput("reset.done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        modelOn = 1'b1;
        repeat (3) @(negedge clk);

        // Full trapezoid.
        clearRecords();
        applyStimulus(10, 3, 2);
        waitFor("profile.idle", 0, 0, 2000);
        repeat (2) @(negedge clk);
        exp = '{3, 6, 9, 10, 7, 4, 1, 0};
        checkSeq("profile.seq", exp);
        checkOutput("profile.donePulses", doneCount, 1);
        checkOutput("profile.holdPeriods", holdPe, 2);

        // Graceful stop while ramping up.
        clearRecords();
        applyStimulus(10, 3, 2);
        waitFor("stop.reach6", 6, 1, 2000);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checkOutput("stop.state", int'(state), 3);
        checkOutput("stop.dutyHeld", int'(duty), 6);
        waitFor("stop.idle", 0, 0, 2000);
        repeat (2) @(negedge clk);
        exp = '{3, 6, 3, 0};
        checkSeq("stop.seq", exp);
        checkOutput("stop.donePulses", doneCount, 1);

        // Abort while ramping down.
        clearRecords();
        applyStimulus(10, 3, 0);
        waitFor("abort.reach7", 7, 3, 2000);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort.duty", int'(duty), 0);
        checkOutput("abort.state", int'(state), 0);
        repeat (3) @(negedge clk);
        checkOutput("abort.donePulses", doneCount, 0);

        // Zero step behaves as a step of one.
        clearRecords();
        applyStimulus(2, 0, 1);
        waitFor("step0.idle", 0, 0, 2000);
        repeat (2) @(negedge clk);
        exp = '{1, 2, 1, 0};
        checkSeq("step0.seq", exp);

        // A second start while busy must not disturb the running profile.
        clearRecords();
        applyStimulus(5, 1, 1);
        repeat (20) @(negedge clk);
        target = 4'd12;
        step = 4'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitFor("busyStart.idle", 0, 0, 3000);
        repeat (2) @(negedge clk);
        exp = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0};
        checkSeq("busyStart.seq", exp);

        // Zero hold, full-scale single step.
        clearRecords();
        applyStimulus(15, 15, 0);
        waitFor("hold0.idle", 0, 0, 2000);
        repeat (2) @(negedge clk);
        exp = '{15, 0};
        checkSeq("hold0.seq", exp);
        checkOutput("hold0.donePulses", doneCount, 1);

        // Asynchronous reset between clock edges.
        applyStimulus(10, 3, 2);
        waitFor("rst.reach3", 3, 1, 2000);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("asyncRst.duty", int'(duty), 0);
        checkOutput("asyncRst.busy", int'(busy), 0);
        checkOutput("asyncRst.state", int'(state), 0);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        // start and abort together in IDLE.
        @(negedge clk);
        target = 4'd5;
        step = 4'd1;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checkOutput("startAbort.state", int'(state), 0);
        repeat (3) @(negedge clk);
        checkOutput("startAbort.busy", int'(busy), 0);

        // Fast period boundaries: ticks are slower than boundaries.
        peDiv = 2;
        repeat (4) @(negedge clk);
        clearRecords();
        applyStimulus(10, 3, 2);
        waitFor("fast.idle", 0, 0, 2000);
        repeat (2) @(negedge clk);
        exp = '{3, 6, 9, 10, 7, 4, 1, 0};
        checkSeq("fast.seq", exp);
        checkOutput("fast.donePulses", doneCount, 1);
        checkOutput("fast.holdPeriods", holdPe, 2);

        modelOn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
